// File: rtl/sd_pkg.sv
// Shared types and sizing constants for the scandoubler controller and line buffer.
// Latency: none, declarations only.
// Backpressure: none.
package sd_pkg;

    // Lock state machine encoding.
    typedef enum logic [1:0] {
        BYPASS  = 2'd0,
        MEASURE = 2'd1,
        ARM     = 2'd2,
        DOUBLE  = 2'd3
    } sd_state_t;

    // Line counter width; the line buffer holds 2**SD_LINE_W pixels.
    localparam int SD_LINE_W   = 10;
    // Shortest line, in ce_x1 ticks, that counts as real video.
    localparam int SD_MIN_LINE = 16;

endpackage

// File: rtl/sd_ce_gen.sv
// Pixel clock-enable generator: ce_x2 every div+1 clk_sys cycles, ce_x1 on every second ce_x2.
// Latency: registered outputs; the first ce_x2 appears 1 cycle after reset release.
// Backpressure: none; free-running, a new div value only takes effect at the next wrap.
module sd_ce_gen #(
    parameter int DIV_W = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    output logic             ce_x2,
    output logic             ce_x1
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;
    logic             phase;
    logic             wrap;

    assign wrap = (div_cnt == div_q);

    // Count 0..div_q, pulse at wrap, and reload the period only at wrap so no period is cut short.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            div_q   <= '0;
            phase   <= 1'b0;
            ce_x2   <= 1'b0;
            ce_x1   <= 1'b0;
        end else begin
            ce_x2 <= wrap;
            ce_x1 <= wrap & phase;
            if (wrap) begin
                div_cnt <= '0;
                div_q   <= div;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scandoubler_ctrl.sv
// Scandoubler controller: measures line/frame geometry and locks before selecting doubled output.
// Latency: measurements and state changes are registered 1 clk_sys cycle after the ce_x1 sample.
// Backpressure: none; video timing is observed only, output is blanked across mode switches.
module scandoubler_ctrl
    import sd_pkg::*;
#(
    parameter int LINE_W        = SD_LINE_W,
    parameter int DIV_W         = 4,
    parameter int STABLE_FRAMES = 4,
    parameter int MIN_LINE      = SD_MIN_LINE
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [DIV_W-1:0]  div,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              sd_req,
    output logic              ce_x2,
    output logic              ce_x1,
    output logic              sd_active,
    output logic              blank,
    output logic [LINE_W-1:0] line_len,
    output logic [9:0]        frame_lines,
    output logic              locked
);

    localparam int                SW        = $clog2(STABLE_FRAMES + 1);
    localparam logic [SW-1:0]     STAB_LAST = SW'(STABLE_FRAMES - 1);
    localparam logic [LINE_W-1:0] HCNT_MAX  = '1;
    localparam logic [LINE_W-1:0] MIN_Q     = LINE_W'(MIN_LINE);

    sd_ce_gen #(
        .DIV_W (DIV_W)
    ) u_ce_gen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .div     (div),
        .ce_x2   (ce_x2),
        .ce_x1   (ce_x1)
    );

    // Measurement state.
    logic              hs_prev;
    logic              vs_prev;
    logic [LINE_W-1:0] hcnt;
    logic              ovf;
    logic [9:0]        vcnt;
    logic              frame_err;
    logic              synced;

    // Lock state.
    sd_state_t         state;
    logic [SW-1:0]     stab_cnt;
    logic              prev_vld;
    logic [LINE_W-1:0] prev_len;
    logic [9:0]        prev_lines;
    logic [LINE_W-1:0] lock_len;
    logic [9:0]        lock_lines;
    logic [1:0]        hs_seen;
    logic              blank_hold;

    // Edge detection and the values a frame closes with, including any hs edge on the same tick.
    logic              hs_fall;
    logic              vs_rise;
    logic              frame_evt;
    logic [LINE_W-1:0] line_len_nxt;
    logic [9:0]        lines_nxt;
    logic              err_nxt;
    logic              frame_valid;
    logic              frame_match;
    logic              line_err;

    assign hs_fall      = ce_x1 & hs_prev & ~hs_in;
    assign vs_rise      = ce_x1 & ~vs_prev & vs_in;
    // The first vs edge after reset only aligns the counters; it closes a partial frame.
    assign frame_evt    = vs_rise & synced;
    assign line_len_nxt = hs_fall ? hcnt : line_len;
    assign lines_nxt    = (hs_fall && vcnt != 10'd1023) ? vcnt + 10'd1 : vcnt;
    assign err_nxt      = frame_err | (hs_fall & ovf);
    assign frame_valid  = ~err_nxt & (line_len_nxt >= MIN_Q);
    assign frame_match  = frame_valid & prev_vld &
                          (line_len_nxt == prev_len) & (lines_nxt == prev_lines);
    assign line_err     = hs_fall & (ovf | (hcnt != lock_len));

    // Line and frame counters, sampled on ce_x1.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            hcnt        <= '0;
            ovf         <= 1'b0;
            vcnt        <= '0;
            frame_err   <= 1'b0;
            synced      <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
        end else if (ce_x1) begin
            hs_prev <= hs_in;
            vs_prev <= vs_in;
            if (hs_fall) begin
                line_len <= hcnt;
                hcnt     <= '0;
                ovf      <= 1'b0;
            end else if (hcnt == HCNT_MAX) begin
                ovf <= 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
            if (vs_rise) begin
                vcnt      <= '0;
                frame_err <= 1'b0;
                synced    <= 1'b1;
                if (synced) begin
                    frame_lines <= lines_nxt;
                end
            end else begin
                vcnt      <= lines_nxt;
                frame_err <= err_nxt;
            end
        end
    end

    // Lock state machine; all outputs are registered here. sd_req loss outranks any frame event.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= BYPASS;
            stab_cnt   <= '0;
            prev_vld   <= 1'b0;
            prev_len   <= '0;
            prev_lines <= '0;
            lock_len   <= '0;
            lock_lines <= '0;
            hs_seen    <= '0;
            blank_hold <= 1'b0;
            sd_active  <= 1'b0;
            blank      <= 1'b0;
            locked     <= 1'b0;
        end else begin
            if (frame_evt) begin
                blank_hold <= 1'b0;
            end
            case (state)
                BYPASS: begin
                    sd_active <= 1'b0;
                    locked    <= 1'b0;
                    blank     <= blank_hold & ~frame_evt;
                    if (sd_req) begin
                        state    <= MEASURE;
                        stab_cnt <= '0;
                        prev_vld <= 1'b0;
                    end
                end
                MEASURE: begin
                    blank <= blank_hold & ~frame_evt;
                    if (!sd_req) begin
                        state <= BYPASS;
                    end else if (frame_evt) begin
                        prev_vld   <= 1'b1;
                        prev_len   <= line_len_nxt;
                        prev_lines <= lines_nxt;
                        if (!frame_match) begin
                            stab_cnt <= '0;
                        end else begin
                            stab_cnt <= stab_cnt + 1'b1;
                            if (stab_cnt == STAB_LAST) begin
                                state      <= ARM;
                                lock_len   <= line_len_nxt;
                                lock_lines <= lines_nxt;
                                locked     <= 1'b1;
                                blank      <= 1'b1;
                            end
                        end
                    end
                end
                ARM: begin
                    blank  <= 1'b1;
                    locked <= 1'b1;
                    if (!sd_req) begin
                        state      <= BYPASS;
                        locked     <= 1'b0;
                        blank_hold <= 1'b1;
                    end else if (frame_evt) begin
                        state     <= DOUBLE;
                        sd_active <= 1'b1;
                        hs_seen   <= '0;
                    end
                end
                DOUBLE: begin
                    if (!sd_req || line_err || (frame_evt && lines_nxt != lock_lines)) begin
                        state      <= BYPASS;
                        sd_active  <= 1'b0;
                        locked     <= 1'b0;
                        blank      <= 1'b1;
                        blank_hold <= 1'b1;
                    end else begin
                        // Keep blanking until two lines have gone into the buffer.
                        if (hs_fall && hs_seen != 2'd2) begin
                            hs_seen <= hs_seen + 2'd1;
                        end
                        blank <= ~((hs_seen == 2'd2) || (hs_fall && hs_seen == 2'd1));
                    end
                end
                default: begin
                    state <= BYPASS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scandoubler_ctrl.sv
// Directed bench for scandoubler_ctrl: CE spacing, lock sequence, error exits, reset.
// Latency: outputs sampled on the falling clk_sys edge.
// Backpressure: none.
module tb_scandoubler_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [3:0] div;
    logic       hs_in;
    logic       vs_in;
    logic       sd_req;
    logic       ce_x2;
    logic       ce_x1;
    logic       sd_active;
    logic       blank;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       locked;

    int checks = 0;
    int fails  = 0;

    scandoubler_ctrl #(
        .LINE_W        (10),
        .DIV_W         (4),
        .STABLE_FRAMES (4),
        .MIN_LINE      (16)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .div         (div),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .sd_req      (sd_req),
        .ce_x2       (ce_x2),
        .ce_x1       (ce_x1),
        .sd_active   (sd_active),
        .blank       (blank),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one ce_x1 tick: inputs change on the falling edge of a cycle where ce_x1 is high.
    task automatic tick(input logic h, input logic v);
        int n = 0;
        @(negedge clk_sys);
        while (!ce_x1 && n < 8) begin
            @(negedge clk_sys);
            n++;
        end
        if (!ce_x1) chk("ce_x1_wait", 32'(ce_x1), 32'd1);
        hs_in = h;
        vs_in = v;
    endtask

    // hs high for 4 ticks at line start; vs high for 8 ticks at the start of a frame's first line.
    task automatic run_line(input int len, input bit first);
        for (int t = 0; t < len; t++) tick(t < 4, first && t < 8);
    endtask

    task automatic run_frame(input int nl, input int len);
        for (int l = 0; l < nl; l++) run_line(len, l == 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x2v;
        logic [31:0] x1v;
        int          n2;
        int          n1;

        // ---- Reset values and CE generator ----
        reset  = 1'b1;
        div    = 4'd3;
        sd_req = 1'b0;
        hs_in  = 1'b0;
        vs_in  = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_ce", 32'({ce_x2, ce_x1}), 32'd0);
        chk("rst_ctl", 32'({sd_active, blank, locked}), 32'd0);
        chk("rst_line_len", 32'(line_len), 32'd0);
        chk("rst_frame_lines", 32'(frame_lines), 32'd0);
        reset = 1'b0;
        x2v = '0;
        x1v = '0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk_sys);
            x2v[k] = ce_x2;
            x1v[k] = ce_x1;
            if (k == 14) div = 4'd1;
        end
        // div=3: pulses at 1,5,9,13; the period running at 14 finishes at 17, then every 2.
        chk("ce_x2_pattern", x2v, 32'h00AA_2222);
        chk("ce_x1_pattern", x1v, 32'h0088_2020);
        div = 4'd0;
        n2 = 0;
        n1 = 0;
        for (int k = 25; k <= 29; k++) begin
            @(negedge clk_sys);
            n2 += int'(ce_x2);
            n1 += int'(ce_x1);
        end
        chk("div0_ce_x2_count", 32'(n2), 32'd5);
        chk("div0_ce_x1_count", 32'(n1), 32'd2);

        // ---- Lock on stable 40x12 timing ----
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        sd_req = 1'b1;
        reset  = 1'b0;
        run_frame(12, 40);
        chk("sync_no_frame_evt", 32'(frame_lines), 32'd0);
        for (int f = 2; f <= 5; f++) begin
            run_frame(12, 40);
            chk("not_locked_early", 32'(locked), 32'd0);
        end
        run_frame(12, 40);
        chk("arm_locked", 32'(locked), 32'd1);
        chk("arm_blank", 32'(blank), 32'd1);
        chk("arm_sd_active", 32'(sd_active), 32'd0);
        chk("line_len_40", 32'(line_len), 32'd39);
        chk("frame_lines_12", 32'(frame_lines), 32'd12);
        run_line(40, 1'b1);
        chk("double_sd_active", 32'(sd_active), 32'd1);
        chk("double_blank_1line", 32'(blank), 32'd1);
        run_line(40, 1'b0);
        chk("double_blank_2lines", 32'(blank), 32'd0);
        for (int l = 2; l < 12; l++) run_line(40, 1'b0);
        run_frame(12, 40);
        chk("double_holds", 32'(sd_active), 32'd1);

        // ---- Short line in DOUBLE ----
        run_line(40, 1'b1);
        run_line(40, 1'b0);
        run_line(40, 1'b0);
        run_line(30, 1'b0);
        for (int t = 0; t < 4; t++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("short_before_edge", 32'(sd_active), 32'd1);
        @(negedge clk_sys);
        chk("short_sd_active_drop", 32'(sd_active), 32'd0);
        chk("short_blank", 32'(blank), 32'd1);
        chk("short_line_len", 32'(line_len), 32'd29);
        for (int t = 5; t < 40; t++) tick(1'b0, 1'b0);
        for (int l = 5; l < 12; l++) run_line(40, 1'b0);
        chk("blank_held_to_vs", 32'(blank), 32'd1);
        run_line(40, 1'b1);
        chk("blank_clear_after_vs", 32'(blank), 32'd0);
        chk("exit_not_locked", 32'({locked, sd_active}), 32'd0);
        for (int l = 1; l < 12; l++) run_line(40, 1'b0);

        // ---- sd_req fall on the frame event that would lock ----
        for (int f = 0; f < 3; f++) run_frame(12, 40);
        tick(1'b1, 1'b1);
        sd_req = 1'b0;
        @(negedge clk_sys);
        chk("req_fall_beats_lock", 32'(locked), 32'd0);
        chk("req_fall_blank", 32'(blank), 32'd0);
        for (int t = 1; t < 40; t++) tick(t < 4, t < 8);
        for (int l = 1; l < 12; l++) run_line(40, 1'b0);
        chk("bypass_after_fall", 32'({locked, sd_active}), 32'd0);

        // ---- Overlong lines never lock ----
        sd_req = 1'b1;
        for (int f = 0; f < 7; f++) begin
            run_frame(1, 1100);
            chk("ovf_no_lock", 32'({locked, sd_active}), 32'd0);
        end
        chk("ovf_line_len_sat", 32'(line_len), 32'd1023);
        chk("ovf_frame_lines", 32'(frame_lines), 32'd1);

        // ---- Reset in DOUBLE, then full relock ----
        for (int f = 0; f < 7; f++) run_frame(12, 40);
        chk("relock_double", 32'(sd_active), 32'd1);
        run_line(40, 1'b1);
        run_line(40, 1'b0);
        run_line(40, 1'b0);
        for (int t = 0; t < 10; t++) tick(t < 4, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_ctl", 32'({ce_x2, ce_x1, sd_active, blank, locked}), 32'd0);
        chk("async_rst_meas", 32'({line_len, frame_lines}), 32'd0);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        for (int f = 1; f <= 5; f++) run_frame(12, 40);
        chk("relock_not_at_5", 32'(locked), 32'd0);
        run_frame(12, 40);
        chk("relock_at_6", 32'(locked), 32'd1);
        run_frame(12, 40);
        chk("relock_sd_active_7", 32'(sd_active), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
